// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM encoding,
// parity modes and the default 50 MHz / 9600 baud divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int DEFAULT_BAUD_DIV = 5208;

  // Even mode sends the XOR of the byte; odd mode sends its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/tx_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled and ticks bit_end_o
// on the last cycle of each bit.
module tx_baud_gen #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_end_o
);

  localparam int CW = $clog2(BAUD_DIV);

  if (BAUD_DIV < 2 || BAUD_DIV > 65535) begin : g_bad_baud_div
    $error("tx_baud_gen: BAUD_DIV must lie in 2..65535");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end_o = enable_i && (cnt_q == CW'(BAUD_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = bit_end_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_module.sv
// UART transmitter: one request sends start bit, 8 data bits LSB first,
// optional parity bit and 1 or 2 stop bits, then pulses TX_Done_Sig.
module tx_module
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic       TX_En_Sig,
  input  logic [7:0] TX_Data,
  output logic       TX_Done_Sig,
  output logic       TX_Busy,
  output logic       TXD
);

  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("tx_module: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("tx_module: STOP_BITS must be 1 or 2");
  end

  uart_state_e state_q;
  logic [7:0]  shift_q;
  logic        par_q;
  logic [2:0]  bit_cnt_q;
  logic        stop_cnt_q;
  logic        armed_q;
  logic        txd_q;
  logic        busy_q;
  logic        done_q;

  logic        baud_clear;
  logic        baud_en;
  logic        bit_end;

  // The counter is held at zero outside the bit-carrying states, so the
  // start bit always begins with a fresh count; later entries ride its wrap.
  assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign baud_en    = !baud_clear;

  tx_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk_i     (CLOCK),
    .rst_ni    (RST_n),
    .clear_i   (baud_clear),
    .enable_i  (baud_en),
    .bit_end_o (bit_end)
  );

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      armed_q    <= 1'b1;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A low request re-arms in every state; it never aborts a frame.
      if (!TX_En_Sig) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (TX_En_Sig && armed_q) begin
            shift_q <= TX_Data;
            par_q   <= parity_bit(TX_Data, PARITY);
            armed_q <= 1'b0;
            busy_q  <= 1'b1;
            txd_q   <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == 3'd7) begin
              if (PARITY != PAR_NONE) begin
                txd_q   <= par_q;
                state_q <= ST_PARITY;
              end else begin
                txd_q      <= 1'b1;
                stop_cnt_q <= 1'b0;
                state_q    <= ST_STOP;
              end
            end else begin
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            txd_q      <= 1'b1;
            stop_cnt_q <= 1'b0;
            state_q    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign TXD         = txd_q;
  assign TX_Busy     = busy_q;
  assign TX_Done_Sig = done_q;

endmodule

// File: doc/tx_module.md
# tx_module

UART transmitter: serialises one byte per request onto `TXD` as start bit, 8 data bits LSB first, optional parity bit and 1 or 2 stop bits. It is the transmit counterpart of `rx_module` and uses the same enable/done handshake style. A control module drives it with `TX_En_Sig`/`TX_Data` and receives `TX_Done_Sig`. A demo top loops received bytes back out through it.

## Interface
- `BAUD_DIV`, default 5208: clock cycles per bit (50 MHz / 9600). Legal range is 2..65535.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even. Value 3 is illegal and must fail elaboration.
- `STOP_BITS`, default 1: 1 or 2. Any other value is illegal.
- `CLOCK` input 1: the single clock, rising edge.
- `RST_n` input 1: asynchronous, active-low reset.
- `TX_En_Sig` input 1: level request to send `TX_Data`.
- `TX_Data` input 8: byte to send. Sampled only at frame acceptance.
- `TX_Done_Sig` output 1: one-cycle pulse at the end of the frame.
- `TX_Busy` output 1: high from frame acceptance through the `TX_Done_Sig` cycle.
- `TXD` output 1: serial line. Idle level is high. Driven from a register.

## Operation
- Reset values: `TXD`=1, `TX_Done_Sig`=0, `TX_Busy`=0. The FSM is in IDLE and the armed flag is set.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE → START: when `TX_En_Sig`=1 and armed.
  - Latches `TX_Data` into an 8-bit shift register.
  - Computes the parity bit from the latched byte: even gives XOR of the bits, odd gives its inverse.
  - Clears armed and sets `TX_Busy`.
- START: `TXD`=0 for `BAUD_DIV` cycles, then → DATA.
- DATA: `TXD`=shift[0]; the register shifts right once per bit. After 8 bits:
  - → PARITY if `PARITY`≠0,
  - otherwise → STOP.
- PARITY: `TXD`=parity bit for one bit time, then → STOP.
- STOP: `TXD`=1 for `STOP_BITS`×`BAUD_DIV` cycles, then → DONE.
- DONE: lasts one cycle. `TX_Done_Sig`=1 and `TX_Busy`=1, then → IDLE. `TXD` stays 1.
- Re-arm rule: armed is set again only when `TX_En_Sig` is sampled low, in any state.
  - If `TX_En_Sig` is still high after DONE, no second frame is sent.
  - The controller must drop `TX_En_Sig` for at least one cycle between frames.
- Behaviour during a frame:
  - Changes on `TX_Data` are ignored.
  - Deasserting `TX_En_Sig` does not abort the frame; it only re-arms.
- Bit counter: 3 bits. The final data bit is the one where the counter reads 7.
- Baud counter: `$clog2(BAUD_DIV)` bits, counting 0..`BAUD_DIV`−1. It reloads to 0 on every state entry and wraps at each bit boundary.

## Timing
- Acceptance latency: `TX_En_Sig` is sampled high in IDLE at edge k, and `TXD` falls at edge k+1.
- Every bit lasts exactly `BAUD_DIV` cycles; there is no drift across the frame.
- Frame length from the `TXD` fall to the last stop-bit cycle is (10 + P + (`STOP_BITS`−1))×`BAUD_DIV` cycles, where P = 1 if parity is enabled, else 0.
- `TX_Done_Sig` is high in the cycle immediately after the last stop-bit cycle.
- With `TX_En_Sig` low→high, the earliest next acceptance is one cycle after DONE. The minimum frame-to-frame gap is therefore 2 idle cycles.
- Reset asserted mid-frame: `TXD` goes to 1 and `TX_Busy`/`TX_Done_Sig` go to 0 immediately, asynchronously. No partial frame resumes after reset release.
- `TX_En_Sig` is asserted from a synchronous source in the `CLOCK` domain. This block has no synchroniser.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (shared encoding style with the receiver),
  - the parity-mode constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`,
  - the default `BAUD_DIV` for the 50 MHz / 9600 configuration.
- One sub-module: `tx_baud_gen`, the bit-period counter.
  - Inputs: clear, enable.
  - Output: one-cycle `bit_end` tick when the count reaches `BAUD_DIV`−1.
  - The FSM advances only on `bit_end`.

## Test plan
All scenarios run with `BAUD_DIV`=16 for simulation.
- 0x55, no parity, 1 stop bit → `TXD` = 0,1,0,1,0,1,0,1,0,1, each level held 16 cycles. `TX_Done_Sig` pulses exactly 160 cycles after the `TXD` fall. `TX_Busy` is high for 161 cycles.
- 0x07 with `PARITY`=2 → parity bit 1. With `PARITY`=1 → parity bit 0. The frame is 176 cycles.
- 0xA3 with `STOP_BITS`=2 → stop level held 32 cycles; `TX_Done_Sig` at cycle 176.
- `TX_En_Sig` held high across two frame times → exactly one frame and one `TX_Done_Sig`. Dropping it for one cycle then raising it → a second frame starts 1 cycle later.
- `TX_Data` changed and `TX_En_Sig` dropped during bit 3 → the originally latched byte is sent intact.
- `RST_n` pulsed low during bit 5 → `TXD`=1 in the same cycle with no `TX_Done_Sig`. After release, `TXD` stays 1 until a new request arrives.
